// File: rtl/brush_painter_pkg.sv
// Shared definitions for the frame-buffer write path: screen geometry,
// colour codes (common with the display decode) and painter states.
package brush_painter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        COL_RED     = 3'd0,
        COL_GREEN   = 3'd1,
        COL_BLUE    = 3'd2,
        COL_YELLOW  = 3'd3,
        COL_PURPLE  = 3'd4,
        COL_WHITE   = 3'd5,
        COL_ERASE   = 3'd6,
        COL_OUTSIDE = 3'd7
    } color_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STAMP = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // "outside" is never stored in the frame buffer; painting it erases.
    function automatic logic [2:0] paint_code(input logic [2:0] sel);
        if (sel == COL_OUTSIDE) begin
            paint_code = COL_ERASE;
        end else begin
            paint_code = sel;
        end
    endfunction

endpackage

// File: rtl/brush_painter_rect_scanner.sv
// Row-major walker over an inclusive signed rectangle; flags positions that
// fall on the visible screen and the final position of the rectangle.
module rect_scanner #(
    parameter int SCREEN_W = brush_painter_pkg::SCREEN_W,
    parameter int SCREEN_H = brush_painter_pkg::SCREEN_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic signed [8:0] x0,
    input  logic signed [8:0] y0,
    input  logic signed [8:0] x1,
    input  logic signed [8:0] y1,
    output logic signed [8:0] x,
    output logic signed [8:0] y,
    output logic              in_bounds,
    output logic              last
);

    logic signed [8:0] x_r;
    logic signed [8:0] y_r;
    logic signed [8:0] x0_r;
    logic signed [8:0] x1_r;
    logic signed [8:0] y1_r;

    // Position and rectangle corners; wraps to x0 at the end of each row.
    // Coordinates past 255 wrap negative, which keeps them out of bounds and
    // leaves the end-of-row equality test intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r  <= 9'sd0;
            y_r  <= 9'sd0;
            x0_r <= 9'sd0;
            x1_r <= 9'sd0;
            y1_r <= 9'sd0;
        end else if (start) begin
            x_r  <= x0;
            y_r  <= y0;
            x0_r <= x0;
            x1_r <= x1;
            y1_r <= y1;
        end else if (step) begin
            if (x_r == x1_r) begin
                x_r <= x0_r;
                y_r <= y_r + 9'sd1;
            end else begin
                x_r <= x_r + 9'sd1;
            end
        end
    end

    assign x         = x_r;
    assign y         = y_r;
    assign in_bounds = !x_r[8] && ($unsigned(x_r) < 9'(SCREEN_W)) &&
                       !y_r[8] && ($unsigned(y_r) < 9'(SCREEN_H));
    assign last      = (x_r == x1_r) && (y_r == y1_r);

endmodule

// File: rtl/brush_painter.sv
// Turns paint/clear requests into colour-code writes: a clipped square brush
// around the cursor, or an erase sweep over the whole screen.
module brush_painter #(
    parameter int SCREEN_W = brush_painter_pkg::SCREEN_W,
    parameter int SCREEN_H = brush_painter_pkg::SCREEN_H,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              paint,
    input  logic              clear,
    input  logic [7:0]        curX,
    input  logic [7:0]        curY,
    input  logic [2:0]        colorSel,
    input  logic [1:0]        brushSize,
    input  logic              wrReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [2:0]        wrData,
    output logic              busy,
    output logic              done
);

    import brush_painter_pkg::*;

    logic [1:0]        state_r;
    logic [2:0]        data_r;
    logic              start_s;
    logic              active_s;
    logic              wr_en_s;
    logic              advance_s;
    logic              step_s;
    logic signed [8:0] rx0_s;
    logic signed [8:0] ry0_s;
    logic signed [8:0] rx1_s;
    logic signed [8:0] ry1_s;
    logic signed [8:0] scan_x_s;
    logic signed [8:0] scan_y_s;
    logic              in_bounds_s;
    logic              last_s;
    logic [ADDR_W-1:0] addr_s;

    // Rectangle to load on acceptance; clear wins over paint.
    always_comb begin
        rx0_s = 9'sd0;
        ry0_s = 9'sd0;
        rx1_s = 9'sd0;
        ry1_s = 9'sd0;
        if (clear) begin
            rx1_s = 9'(SCREEN_W - 1);
            ry1_s = 9'(SCREEN_H - 1);
        end else begin
            rx0_s = $signed({1'b0, curX} - {7'd0, brushSize});
            ry0_s = $signed({1'b0, curY} - {7'd0, brushSize});
            rx1_s = $signed({1'b0, curX} + {7'd0, brushSize});
            ry1_s = $signed({1'b0, curY} + {7'd0, brushSize});
        end
    end

    assign start_s   = (state_r == ST_IDLE) && (clear || paint);
    assign active_s  = (state_r == ST_STAMP) || (state_r == ST_CLEAR);
    assign wr_en_s   = active_s && in_bounds_s;
    assign advance_s = active_s && (!wr_en_s || wrReady);
    assign step_s    = advance_s && !last_s;

    rect_scanner #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .step      (step_s),
        .x0        (rx0_s),
        .y0        (ry0_s),
        .x1        (rx1_s),
        .y1        (ry1_s),
        .x         (scan_x_s),
        .y         (scan_y_s),
        .in_bounds (in_bounds_s),
        .last      (last_s)
    );

    // Painter sequencing and latched write colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            data_r  <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        state_r <= ST_CLEAR;
                        data_r  <= COL_ERASE;
                    end else if (paint) begin
                        state_r <= ST_STAMP;
                        data_r  <= paint_code(colorSel);
                    end
                end
                ST_STAMP, ST_CLEAR: begin
                    if (advance_s && last_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Only in-bounds positions reach here, so the row-major address is exact.
    assign addr_s = ADDR_W'($unsigned(scan_y_s)) * ADDR_W'(SCREEN_W) +
                    ADDR_W'($unsigned(scan_x_s));

    assign wrEn   = wr_en_s;
    assign wrAddr = wr_en_s ? addr_s : {ADDR_W{1'b0}};
    assign wrData = wr_en_s ? data_r : 3'd0;
    assign busy   = (state_r != ST_IDLE);
    assign done   = (state_r == ST_DONE);

endmodule

// File: tb/tb_brush_painter.sv
// Randomised bench for brush_painter: a footprint/clip model builds the
// expected write list for each request and a monitor scores every handshake.
module tb_brush_painter;

    logic        clk = 1'b0;
    logic        reset;
    logic        paint;
    logic        clear;
    logic [7:0]  curX;
    logic [7:0]  curY;
    logic [2:0]  colorSel;
    logic [1:0]  brushSize;
    logic        wrReady;
    logic        wrEn;
    logic [14:0] wrAddr;
    logic [2:0]  wrData;
    logic        busy;
    logic        done;

    brush_painter #(.SCREEN_W(160), .SCREEN_H(120), .ADDR_W(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .paint     (paint),
        .clear     (clear),
        .curX      (curX),
        .curY      (curY),
        .colorSel  (colorSel),
        .brushSize (brushSize),
        .wrReady   (wrReady),
        .wrEn      (wrEn),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_total = 0;
    int          n_pass  = 0;
    bit          mon_en  = 1'b0;
    int          rdy_pct = 100;
    bit          stall_p = 1'b0;
    logic [14:0] stall_addr;
    logic [2:0]  stall_data;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-buffer backpressure, changed just after each rising edge.
    initial begin
        wrReady = 1'b1;
        forever begin
            @(posedge clk);
            #1 wrReady = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Scoreboard: every accepted write must be the next expected pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_p) begin
                    check_val("hold_en", longint'(wrEn), 1);
                    check_val("hold_addr", longint'(wrAddr), longint'(stall_addr));
                    check_val("hold_data", longint'(wrData), longint'(stall_data));
                end
                if (wrEn && wrReady) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_write", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_val("wr_addr", longint'(wrAddr), mon_e.addr);
                        check_val("wr_data", longint'(wrData), mon_e.data);
                    end
                end
                stall_p    = wrEn && !wrReady;
                stall_addr = wrAddr;
                stall_data = wrData;
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    task automatic do_op(input bit clr, input bit pnt, input int cx, input int cy,
                         input int col, input int r, input int pct, input bit inject);
        int slots;
        int cyc;
        int budget;
        int d;
        rdy_pct = pct;
        d = (col == 7) ? 6 : col;
        if (clr) begin
            slots = 160 * 120;
            for (int a = 0; a < slots; a++) exp_q.push_back('{a, 6});
        end else begin
            slots = (2 * r + 1) * (2 * r + 1);
            for (int yy = cy - r; yy <= cy + r; yy++)
                for (int xx = cx - r; xx <= cx + r; xx++)
                    if (xx >= 0 && xx < 160 && yy >= 0 && yy < 120)
                        exp_q.push_back('{yy * 160 + xx, d});
        end
        @(posedge clk);
        #1;
        clear     = clr;
        paint     = pnt;
        curX      = 8'(cx);
        curY      = 8'(cy);
        colorSel  = 3'(col);
        brushSize = 2'(r);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        paint     = 1'b0;
        curX      = 8'($urandom);
        curY      = 8'($urandom);
        colorSel  = 3'($urandom);
        brushSize = 2'($urandom);
        budget = slots * 10 + 50;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 20) paint = 1'b1;
            if (inject && cyc == 22) paint = 1'b0;
        end while (!done && cyc < budget);
        check_val("done_seen", longint'(done), 1);
        if (pct == 100) check_val("done_latency", cyc, slots + 1);
        @(negedge clk);
        check_val("busy_after", longint'(busy), 0);
        check_val("done_one_cycle", longint'(done), 0);
        check_val("writes_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        paint     = 1'b0;
        clear     = 1'b0;
        curX      = 8'd0;
        curY      = 8'd0;
        colorSel  = 3'd0;
        brushSize = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_wren", longint'(wrEn), 0);
        check_val("rst_addr", longint'(wrAddr), 0);
        check_val("rst_data", longint'(wrData), 0);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_done", longint'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        do_op(0, 1, 10, 20, 0, 0, 100, 0);
        do_op(0, 1, 0, 0, 1, 1, 100, 0);
        do_op(0, 1, 50, 50, 2, 1, 40, 0);
        do_op(0, 1, 159, 119, 7, 3, 100, 0);
        do_op(0, 1, 200, 200, 3, 3, 100, 0);
        do_op(0, 1, 255, 2, 5, 3, 100, 0);
        do_op(1, 1, 5, 5, 0, 2, 100, 1);

        for (int i = 0; i < 40; i++) begin
            do_op(0, 1, int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? 100 : 60, 0);
        end

        // Reset in the middle of an erase sweep.
        rdy_pct = 100;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        mon_en = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("midrst_wren", longint'(wrEn), 0);
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_done", longint'(done), 0);
        @(negedge clk);
        check_val("midrst_wren2", longint'(wrEn), 0);
        exp_q.delete();
        mon_en = 1'b1;
        do_op(0, 1, 80, 60, 4, 2, 100, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
